eth_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 30 +++
 rtl/crc32_eth.sv | 28 ++
 rtl/eth_tx_framer.sv | 157 +++++++++++++++
 tb/tb_eth_tx_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants, framer state encoding and the byte-wise CRC-32 step.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
   localparam int          ETH_MIN_FRAME     = 60;
   localparam int          ETH_IFG           = 12;
   localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;

   typedef enum logic [2:0] {
      TX_IDLE = 3'd0,
      TX_PRE  = 3'd1,
      TX_SFD  = 3'd2,
      TX_DATA = 3'd3,
      TX_PAD  = 3'd4,
      TX_FCS  = 3'd5,
      TX_IFG  = 3'd6
   } tx_state_t;

   // Reflected CRC-32 (IEEE 802.3), one byte, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_eth.sv
// Ethernet FCS accumulator: preset to all ones on clear, crc_out is the complemented
// remainder ready to transmit least-significant byte first.
module crc32_eth
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   logic [31:0] crc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_reg <= 32'hFFFFFFFF;
      end else if (clear) begin
         crc_reg <= 32'hFFFFFFFF;
      end else if (enable) begin
         crc_reg <= crc32_byte(crc_reg, data_in);
      end
   end

   assign crc_out = ~crc_reg;

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding to minimum length,
// FCS append and inter-frame gap enforcement over a byte valid/ready stream.
module eth_tx_framer
   import eth_pkg::*;
#(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
   parameter int IFG_BYTES       = ETH_IFG
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   output logic       s_tready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       busy,
   output logic       underrun
);

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
   localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_BYTES);

   tx_state_t   state_reg, state_next;
   logic [7:0]  phase_reg, phase_next;
   logic [15:0] byte_cnt_reg, byte_cnt_next;
   logic [23:0] hold_reg, hold_next;
   logic [7:0]  txd_reg, txd_next;
   logic        tx_en_reg, tx_en_next;
   logic        tx_er_reg, tx_er_next;
   logic        underrun_reg, underrun_next;

   logic        crc_clear, crc_en;
   logic [7:0]  crc_din;
   logic [31:0] crc_out;
   logic [15:0] byte_cnt_inc;
   logic [16:0] cnt_plus1;

   crc32_eth u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (crc_clear),
      .enable  (crc_en),
      .data_in (crc_din),
      .crc_out (crc_out)
   );

   assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;
   assign cnt_plus1    = {1'b0, byte_cnt_reg} + 17'd1;

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg + 8'd1;
      byte_cnt_next = byte_cnt_reg;
      hold_next     = hold_reg;
      txd_next      = 8'h00;
      tx_en_next    = 1'b0;
      tx_er_next    = 1'b0;
      underrun_next = 1'b0;
      crc_clear     = 1'b0;
      crc_en        = 1'b0;
      crc_din       = 8'h00;

      case (state_reg)
         TX_IDLE: begin
            crc_clear     = 1'b1;
            byte_cnt_next = 16'd0;
            if (s_tvalid) state_next = TX_PRE;
         end
         TX_PRE: begin
            txd_next   = ETH_PREAMBLE_BYTE;
            tx_en_next = 1'b1;
            if (phase_reg == PRE_LAST) state_next = TX_SFD;
         end
         TX_SFD: begin
            txd_next   = ETH_SFD_BYTE;
            tx_en_next = 1'b1;
            state_next = TX_DATA;
         end
         TX_DATA: begin
            tx_en_next = 1'b1;
            if (s_tvalid) begin
               txd_next      = s_tdata;
               crc_en        = 1'b1;
               crc_din       = s_tdata;
               byte_cnt_next = byte_cnt_inc;
               if (s_tlast) state_next = (cnt_plus1 < MIN_LEN) ? TX_PAD : TX_FCS;
            end else begin
               // Starved mid-frame: flag the error on the wire and abandon the frame.
               tx_er_next    = 1'b1;
               underrun_next = 1'b1;
               state_next    = TX_IFG;
            end
         end
         TX_PAD: begin
            tx_en_next    = 1'b1;
            crc_en        = 1'b1;
            byte_cnt_next = byte_cnt_inc;
            if (cnt_plus1 >= MIN_LEN) state_next = TX_FCS;
         end
         TX_FCS: begin
            tx_en_next = 1'b1;
            case (phase_reg[1:0])
               2'd0: begin
                  txd_next  = crc_out[7:0];
                  hold_next = crc_out[31:8];
               end
               2'd1: txd_next = hold_reg[7:0];
               2'd2: txd_next = hold_reg[15:8];
               2'd3: begin
                  txd_next   = hold_reg[23:16];
                  state_next = TX_IFG;
               end
            endcase
         end
         TX_IFG: begin
            if (phase_reg == IFG_LAST) state_next = TX_IDLE;
         end
         default: state_next = TX_IDLE;
      endcase

      if (state_next != state_reg) phase_next = 8'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= TX_IDLE;
         phase_reg    <= 8'd0;
         byte_cnt_reg <= 16'd0;
         hold_reg     <= 24'd0;
         txd_reg      <= 8'h00;
         tx_en_reg    <= 1'b0;
         tx_er_reg    <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         byte_cnt_reg <= byte_cnt_next;
         hold_reg     <= hold_next;
         txd_reg      <= txd_next;
         tx_en_reg    <= tx_en_next;
         tx_er_reg    <= tx_er_next;
         underrun_reg <= underrun_next;
      end
   end

   assign s_tready   = (state_reg == TX_DATA);
   assign busy       = (state_reg != TX_IDLE);
   assign gmii_txd   = txd_reg;
   assign gmii_tx_en = tx_en_reg;
   assign gmii_tx_er = tx_er_reg;
   assign underrun   = underrun_reg;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: one default instance and one with padding disabled,
// selected by sel; table-driven frames plus underrun, back-to-back and reset sequences.
module tb_eth_tx_framer;
   import eth_pkg::*;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      bit          min0;
      int          len;
      int          kind;
      int          exp_en;
      bit          use_fixed;
      logic [31:0] fixed_fcs;
   } vec_t;

   localparam int K_ASCII = 0;
   localparam int K_AB    = 1;
   localparam int K_INC   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0;
   logic       s_tlast = 1'b0;

   logic       tv_d, tv_z, rdy_d, rdy_z, en_d, en_z, er_d, er_z, busy_d, busy_z, und_d, und_z;
   logic [7:0] txd_d, txd_z;
   logic       s_tready, tx_en, tx_er, busy, und;
   logic [7:0] txd;

   int n_chk = 0;
   int n_fail = 0;

   always #4 clk = ~clk;

   assign tv_d = s_tvalid & ~sel;
   assign tv_z = s_tvalid & sel;

   eth_tx_framer dut (
      .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(tv_d), .s_tlast(s_tlast),
      .s_tready(rdy_d), .gmii_txd(txd_d), .gmii_tx_en(en_d), .gmii_tx_er(er_d),
      .busy(busy_d), .underrun(und_d)
   );

   eth_tx_framer #(.MIN_FRAME_BYTES(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(tv_z), .s_tlast(s_tlast),
      .s_tready(rdy_z), .gmii_txd(txd_z), .gmii_tx_en(en_z), .gmii_tx_er(er_z),
      .busy(busy_z), .underrun(und_z)
   );

   assign s_tready = sel ? rdy_z  : rdy_d;
   assign txd      = sel ? txd_z  : txd_d;
   assign tx_en    = sel ? en_z   : en_d;
   assign tx_er    = sel ? er_z   : er_d;
   assign busy     = sel ? busy_z : busy_d;
   assign und      = sel ? und_z  : und_d;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cmp_bytes(input string nm, input bq_t got, input bq_t exp);
      n_chk++;
      if (got.size() != exp.size()) begin
         n_fail++;
         $display("FAIL %s: got %0d bytes, expected %0d bytes", nm, got.size(), exp.size());
      end else begin
         for (int k = 0; k < exp.size(); k++) begin
            if (got[k] !== exp[k]) begin
               n_fail++;
               $display("FAIL %s: byte %0d got 0x%02h, expected 0x%02h", nm, k, got[k], exp[k]);
               break;
            end
         end
      end
   endtask

   function automatic logic [31:0] sw_crc(input bq_t d);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[k]) begin
         c = c ^ {24'h000000, d[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic make_pl(input int kind, input int len, output bq_t pl);
      pl = {};
      for (int k = 0; k < len; k++) begin
         if (kind == K_ASCII)   pl.push_back(8'(8'h31 + k));
         else if (kind == K_AB) pl.push_back(8'hAB);
         else                   pl.push_back(8'(k));
      end
   endtask

   task automatic build_exp(input bq_t pl, input int minlen, input bit use_fixed,
                            input logic [31:0] fixed, output bq_t exp);
      bq_t padded;
      logic [31:0] f;
      padded = pl;
      while (padded.size() < minlen) padded.push_back(8'h00);
      f = use_fixed ? fixed : sw_crc(padded);
      exp = {};
      for (int k = 0; k < 7; k++) exp.push_back(8'h55);
      exp.push_back(8'hD5);
      foreach (padded[k]) exp.push_back(padded[k]);
      for (int k = 0; k < 4; k++) exp.push_back(f[8*k +: 8]);
   endtask

   // Presents bytes until accepted; drop_at >= 0 starves the framer before that byte.
   task automatic drive(input bq_t d, input int drop_at);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < d.size() && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (i == drop_at) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            @(posedge clk);
            break;
         end
         s_tvalid = 1'b1;
         s_tdata  = d[i];
         s_tlast  = (i == d.size() - 1);
         #1;
         acc = s_tready;
         @(posedge clk);
         if (acc) i++;
      end
      if (guard >= 3000) check("drive_timeout", 32'(i), 32'(d.size()));
   endtask

   task automatic capture(output bq_t got, output int n_en, output int n_er, output int n_und);
      int guard = 0;
      got = {};
      n_en = 0; n_er = 0; n_und = 0;
      while (!tx_en && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!tx_en) begin
         check("tx_en_rise_timeout", 32'(tx_en), 32'd1);
         return;
      end
      while (tx_en && guard < 3000) begin
         got.push_back(txd);
         n_en++;
         if (tx_er) n_er++;
         if (und) n_und++;
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic gap(input int limit, output int n_low, output int n_rdy);
      n_low = 0; n_rdy = 0;
      while (!tx_en && n_low < limit) begin
         n_low++;
         if (s_tready) n_rdy++;
         @(negedge clk);
      end
   endtask

   vec_t vecs[6];

   initial begin
      bq_t pl, pl2, exp, exp2, got, got2;
      int  n_en, n_er, n_und, n_low, n_rdy, bz;

      vecs[0] = '{1'b1,  9, K_ASCII, 21, 1'b1, 32'hCBF43926};
      vecs[1] = '{1'b1,  1, K_AB,    13, 1'b0, 32'h0};
      vecs[2] = '{1'b0,  1, K_AB,    72, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 59, K_INC,   72, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 60, K_INC,   72, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 64, K_INC,   76, 1'b0, 32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'h00);
      check("rst_tx_en", 32'(tx_en), 32'd0);
      check("rst_tx_er", 32'(tx_er), 32'd0);
      check("rst_tready", 32'(s_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(und), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         sel = vecs[v].min0;
         @(negedge clk);
         make_pl(vecs[v].kind, vecs[v].len, pl);
         build_exp(pl, vecs[v].min0 ? 0 : 60, vecs[v].use_fixed, vecs[v].fixed_fcs, exp);
         fork
            begin
               drive(pl, -1);
               @(negedge clk);
               s_tvalid = 1'b0;
               s_tlast  = 1'b0;
            end
            capture(got, n_en, n_er, n_und);
         join
         $display("vec %0d: min0=%0d len=%0d tx_en_cycles=%0d bytes=%0d", v, vecs[v].min0,
                  vecs[v].len, n_en, got.size());
         check($sformatf("v%0d_en_len", v), 32'(n_en), 32'(vecs[v].exp_en));
         cmp_bytes($sformatf("v%0d_bytes", v), got, exp);
         check($sformatf("v%0d_tx_er", v), 32'(n_er), 32'd0);
         check($sformatf("v%0d_underrun", v), 32'(n_und), 32'd0);
         check($sformatf("v%0d_busy_ifg", v), 32'(busy), 32'd1);
         gap(16, n_low, n_rdy);
         check($sformatf("v%0d_ifg_low", v), 32'(n_low), 32'd16);
         check($sformatf("v%0d_ifg_tready", v), 32'(n_rdy), 32'd0);
         check($sformatf("v%0d_busy_idle", v), 32'(busy), 32'd0);
      end

      // Underrun after 20 bytes, next frame queued immediately behind it
      sel = 1'b0;
      @(negedge clk);
      make_pl(K_INC, 25, pl);
      exp = {};
      for (int k = 0; k < 7; k++) exp.push_back(8'h55);
      exp.push_back(8'hD5);
      for (int k = 0; k < 20; k++) exp.push_back(pl[k]);
      exp.push_back(8'h00);
      make_pl(K_ASCII, 9, pl2);
      build_exp(pl2, 60, 1'b0, 32'h0, exp2);
      fork
         begin
            drive(pl, 20);
            drive(pl2, -1);
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         begin
            capture(got, n_en, n_er, n_und);
            $display("underrun: tx_en_cycles=%0d tx_er=%0d underrun=%0d", n_en, n_er, n_und);
            check("ur_en_len", 32'(n_en), 32'd29);
            cmp_bytes("ur_bytes", got, exp);
            check("ur_tx_er", 32'(n_er), 32'd1);
            check("ur_pulse", 32'(n_und), 32'd1);
            if (got.size() == 29) check("ur_er_last", 32'(got[28]), 32'h00);
            gap(40, n_low, n_rdy);
            $display("underrun gap: low=%0d", n_low);
            check("ur_gap", 32'(n_low), 32'd13);
            check("ur_gap_tready", 32'(n_rdy), 32'd0);
            capture(got2, n_en, n_er, n_und);
            $display("after underrun: tx_en_cycles=%0d", n_en);
            check("ur_next_en_len", 32'(n_en), 32'd72);
            cmp_bytes("ur_next_bytes", got2, exp2);
         end
      join
      gap(16, n_low, n_rdy);

      // Two frames back-to-back with s_tvalid held high
      make_pl(K_INC, 64, pl);
      build_exp(pl, 60, 1'b0, 32'h0, exp);
      make_pl(K_AB, 1, pl2);
      build_exp(pl2, 60, 1'b0, 32'h0, exp2);
      fork
         begin
            drive(pl, -1);
            drive(pl2, -1);
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         begin
            capture(got, n_en, n_er, n_und);
            $display("b2b frame A: tx_en_cycles=%0d", n_en);
            check("b2b_a_en_len", 32'(n_en), 32'd76);
            cmp_bytes("b2b_a_bytes", got, exp);
            gap(40, n_low, n_rdy);
            $display("b2b gap: low=%0d tready_high=%0d", n_low, n_rdy);
            check("b2b_gap", 32'(n_low), 32'd13);
            check("b2b_gap_tready", 32'(n_rdy), 32'd0);
            capture(got2, n_en, n_er, n_und);
            $display("b2b frame B: tx_en_cycles=%0d", n_en);
            check("b2b_b_en_len", 32'(n_en), 32'd72);
            cmp_bytes("b2b_b_bytes", got2, exp2);
         end
      join
      gap(16, n_low, n_rdy);

      // Reset asserted during the third preamble byte on the pins
      make_pl(K_INC, 2, pl);
      build_exp(pl, 60, 1'b0, 32'h0, exp);
      fork
         begin
            drive(pl, -1);
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
         end
         begin
            int highs = 0;
            int guard = 0;
            while (highs < 3 && guard < 100) begin
               @(negedge clk);
               guard++;
               if (tx_en) highs++;
            end
            check("rstm_reach_pre3", 32'(highs), 32'd3);
            rst_n = 1'b0;
            #1;
            check("rstm_tx_en", 32'(tx_en), 32'd0);
            check("rstm_txd", 32'(txd), 32'h00);
            check("rstm_busy", 32'(busy), 32'd0);
            bz = 0;
            repeat (3) begin
               @(negedge clk);
               if (busy || tx_en) bz++;
            end
            check("rstm_held_idle", 32'(bz), 32'd0);
            rst_n = 1'b1;
            capture(got, n_en, n_er, n_und);
            $display("after reset: tx_en_cycles=%0d", n_en);
            check("rstm_en_len", 32'(n_en), 32'd72);
            cmp_bytes("rstm_bytes", got, exp);
         end
      join
      gap(16, n_low, n_rdy);
      check("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
